// File: rtl/timer_bank_pkg.sv
// timer_bank_pkg: shared definitions for the timer bank.
//   - per-channel FSM state encoding
//   - register offsets (addr[3:2]) inside a 16-byte channel window
//   - CTRL bit positions and MODE codes
package timer_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CNT  = 2'd2,
    ST_INT  = 2'd3
  } ch_state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_MODE_LSB = 1;
  localparam int unsigned CTRL_IM       = 3;
  localparam int unsigned CTRL_PS_LSB   = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  localparam int unsigned CH_STRIDE = 16;

endpackage

// File: rtl/timer_channel.sv
// timer_channel: one down-counting timer channel.
//   Holds CTRL (EN, MODE, IM[, PS]), PRESET, COUNT and the pending bit,
//   runs the IDLE/LOAD/CNT/INT FSM and applies byte-enabled bus writes.
// Ports:
//   clk, reset (async, active-low)
//   wr_en    - bus write addressed to this channel
//   reg_sel  - register offset (addr[3:2])
//   byteen   - write byte enables
//   wdata    - write data
//   rdata    - read data for reg_sel, zero-extended to 32 bits
//   irq      - pending & IM
// Optional: TIMER_BANK_PRESCALE_EN adds CTRL[7:4] PS and a prescale counter.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [1:0]  reg_sel,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  ch_state_e        state_q, state_d;
  logic             en_q, en_d;
  logic [1:0]       mode_q, mode_d;
  logic             im_q, im_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pend_q, pend_d;
  logic             pend_set;
  logic             fsm_clr_en;
  logic             tick;
  logic [31:0]      preset_wr;

`ifdef TIMER_BANK_PRESCALE_EN
  logic [3:0]  ps_q, ps_d;
  logic [14:0] psc_q, psc_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      mode_q   <= '0;
      im_q     <= 1'b0;
      preset_q <= '0;
      count_q  <= '0;
      pend_q   <= 1'b0;
`ifdef TIMER_BANK_PRESCALE_EN
      ps_q     <= '0;
      psc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      mode_q   <= mode_d;
      im_q     <= im_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      pend_q   <= pend_d;
`ifdef TIMER_BANK_PRESCALE_EN
      ps_q     <= ps_d;
      psc_q    <= psc_d;
`endif
    end
  end

  // FSM next state and counter update
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    pend_set   = 1'b0;
    fsm_clr_en = 1'b0;
`ifdef TIMER_BANK_PRESCALE_EN
    psc_d = psc_q;
    tick  = (psc_q == 15'((32'd1 << ps_q) - 32'd1));
`else
    tick  = 1'b1;
`endif
    if (!en_q) begin
      state_d = ST_IDLE;
`ifdef TIMER_BANK_PRESCALE_EN
      psc_d   = '0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_LOAD;
        ST_LOAD: begin
          count_d = preset_q;
          state_d = ST_CNT;
`ifdef TIMER_BANK_PRESCALE_EN
          psc_d   = '0;
`endif
        end
        ST_CNT: begin
`ifdef TIMER_BANK_PRESCALE_EN
          psc_d = tick ? '0 : psc_q + 15'd1;
`endif
          if (tick) begin
            if (count_q == '0) begin
              pend_set = 1'b1;
              state_d  = ST_INT;
            end else begin
              count_d = count_q - CNT_W'(1);
            end
          end
        end
        ST_INT: begin
          if (mode_q != MODE_AUTO) fsm_clr_en = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Register writes. The FSM's one-shot EN clear is applied first so that a
  // same-edge CTRL byte-0 write overrides it; a same-edge expiry beats W1C.
  always_comb begin
    en_d      = en_q & ~fsm_clr_en;
    mode_d    = mode_q;
    im_d      = im_q;
    pend_d    = pend_q;
    preset_wr = 32'(preset_q);
`ifdef TIMER_BANK_PRESCALE_EN
    ps_d      = ps_q;
`endif
    if (wr_en) begin
      case (reg_sel)
        REG_CTRL: begin
          if (byteen[0]) begin
            en_d   = wdata[CTRL_EN];
            mode_d = wdata[CTRL_MODE_LSB +: 2];
            im_d   = wdata[CTRL_IM];
`ifdef TIMER_BANK_PRESCALE_EN
            ps_d   = wdata[CTRL_PS_LSB +: 4];
`endif
          end
        end
        REG_PRESET: begin
          for (int unsigned k = 0; k < 4; k++) begin
            if (byteen[k]) preset_wr[8*k +: 8] = wdata[8*k +: 8];
          end
        end
        REG_STATUS: begin
          if (byteen[0] && wdata[0]) pend_d = 1'b0;
        end
        default: ;
      endcase
    end
    if (pend_set) pend_d = 1'b1;
    preset_d = preset_wr[CNT_W-1:0];
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
`ifdef TIMER_BANK_PRESCALE_EN
      REG_CTRL:   rdata = {24'd0, ps_q, im_q, mode_q, en_q};
`else
      REG_CTRL:   rdata = {28'd0, im_q, mode_q, en_q};
`endif
      REG_PRESET: rdata = 32'(preset_q);
      REG_COUNT:  rdata = 32'(count_q);
      REG_STATUS: rdata = {31'd0, pend_q};
      default:    rdata = '0;
    endcase
  end

  assign irq = pend_q & im_q;

endmodule

// File: rtl/timer_bank.sv
// timer_bank: bank of NUM_CH down-counting timers on the CPU data bus.
//   Address decode, read mux and irq vector; channel logic in timer_channel.
// Ports:
//   clk, reset (async, active-low)
//   addr   - byte address from bridge
//   we     - write strobe (qualified by hit)
//   byteen - write byte enables
//   wdata  - write data
//   rdata  - read data, combinational from addr (0 when not hit)
//   hit    - addr inside [BASE_ADDR, BASE_ADDR+16*NUM_CH), word aligned
//   irq    - per-channel interrupt (bit i = channel i)
// Optional: TIMER_BANK_PRESCALE_EN enables the per-channel prescaler.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned NUM_CH    = 2,
  parameter int unsigned CNT_W     = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr,
  input  logic              we,
  input  logic [3:0]        byteen,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              hit,
  output logic [NUM_CH-1:0] irq
);

  logic [31:0] offset;
  logic [2:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic [31:0] ch_rdata [NUM_CH];

  assign offset  = addr - BASE_ADDR;
  assign hit     = (addr >= BASE_ADDR) && (offset < 32'(CH_STRIDE * NUM_CH)) &&
                   (addr[1:0] == 2'b00);
  assign ch_sel  = offset[6:4];
  assign reg_sel = addr[3:2];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    timer_channel #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk    (clk),
      .reset  (reset),
      .wr_en  (we && hit && (ch_sel == 3'(g))),
      .reg_sel(reg_sel),
      .byteen (byteen),
      .wdata  (wdata),
      .rdata  (ch_rdata[g]),
      .irq    (irq[g])
    );
  end

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (hit && (ch_sel == 3'(i))) rdata = ch_rdata[i];
    end
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised bank of NUM_CH identical down-counting timer channels on the CPU data bus behind the system bridge.
- Replaces the fixed pair of single timers; channel count, counter width and base address are parameters.
- Adds a per-channel interrupt mask, write-1-to-clear pending status and byte-enable writes.
- irq vector feeds the CPU HWInt field directly (bit i = channel i).

Parameters:
NUM_CH, 2, number of channels (1..8)
CNT_W, 32, PRESET/COUNT width (8..32); reads zero-extend to 32 bits
BASE_ADDR, 32'h0000_7F00, byte address of channel 0; channel i window = BASE_ADDR + 16*i

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
addr  in  32  byte address from bridge
we  in  1  write strobe, qualified by hit
byteen  in  4  byte enables for writes
wdata  in  32  write data
rdata  out  32  read data, combinational from addr
hit  out  1  addr within [BASE_ADDR, BASE_ADDR+16*NUM_CH), word aligned
irq  out  NUM_CH  per-channel interrupt = pending & IM

Behaviour:
- Decode: ch = (addr-BASE_ADDR)>>4; reg = addr[3:2]. Offsets: 0x0 CTRL, 0x4 PRESET, 0x8 COUNT (read-only; writes ignored), 0xC STATUS.
- CTRL: [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM; other bits read 0.
- STATUS: [0] pending; writing 1 clears it, writing 0 has no effect.
- Writes: on a rising clk edge when we & hit; only bytes with byteen[k]=1 update. PRESET bits above CNT_W are dropped.
- rdata = 0 when hit=0 or for an unimplemented field.
- Reset (reset=0, async): all CTRL, PRESET, COUNT and pending bits = 0; every state = IDLE; irq = 0; rdata reflects the zeroed registers.
- Per-channel FSM (one update per edge):
  - IDLE: if EN then LOAD.
  - LOAD: COUNT <= PRESET; next state CNT.
  - CNT: if EN=0 then IDLE with COUNT held. Else if COUNT==0 then pending <= 1 and next state INT. Else COUNT <= COUNT-1.
  - INT: MODE one-shot clears EN; MODE auto-reload keeps EN. Next state IDLE.
- Timing, CTRL write with EN=1 at edge t:
  - LOAD entered at t+1; COUNT=P after t+2.
  - COUNT=0 after t+2+P; pending=1 after t+3+P.
  - Auto-reload period = P+4 cycles. P=0 is legal: pending sets 3 edges after enable.
- Boundaries:
  - PRESET write mid-count does not affect the current COUNT; it applies at the next LOAD.
  - Writing EN=0 in any state: state goes to IDLE on the next edge, COUNT frozen.
  - Writing EN=1 while already counting does not restart the count.
  - Pending set and W1C on the same edge: set wins.
  - pending is sticky in both modes; IM=0 masks irq but does not stop pending from setting.
  - CTRL write to channel i on the edge channel i leaves INT in one-shot mode: the bus write wins.
  - Channels are fully independent; simultaneous expiries set their own bits only.

Optional Feature:
- Macro TIMER_BANK_PRESCALE_EN.
- Defined: CTRL[7:4] = PS. In CNT, COUNT decrements only when a per-channel prescale counter reaches 2^PS-1. The prescale counter is cleared at LOAD and when EN=0. Auto-reload period = (P+1)*2^PS + 3 cycles.
- Undefined: CTRL[7:4] read 0, writes ignored, decrement every cycle, no prescale registers synthesised.

Decomposition:
- Package timer_bank_pkg: FSM state encoding (IDLE/LOAD/CNT/INT), register offsets, CTRL bit positions, MODE codes.
- Sub-module timer_channel: FSM, CTRL/PRESET/COUNT/pending, byte-enable write and prescaler. Instantiated NUM_CH times by a generate loop.
- timer_bank itself holds only address decode, read mux and the irq vector.

Test Plan:
- Reset with all registers written nonzero: assert reset=0 mid-count -> all reads 0 and irq=0 immediately, no clock edge needed.
- Ch0 PRESET=5, CTRL=0x9 (EN, one-shot, IM) -> irq[0] rises exactly 8 edges after the CTRL write; CTRL reads 0x8; COUNT holds 0; STATUS W1C drops irq[0] the next edge.
- Ch1 PRESET=3, CTRL=0xB (auto-reload) -> pending re-sets every 7 cycles; W1C and expiry on the same edge leaves pending=1.
- NUM_CH=4: write ch3 PRESET=0x12345678 with byteen=4'b0011 over an old value 0 -> reads 0x00005678; addr=BASE+0x40 -> hit=0, rdata=0, no register changes.
- Mid-count EN=0 at COUNT=2, then PRESET=10, then EN=1 -> COUNT frozen at 2, then reloads to 10 two edges after re-enable; IM=0 case: pending=1, irq=0.
- With TIMER_BANK_PRESCALE_EN: PRESET=2, PS=2, auto-reload -> period 15 cycles. Without the macro: CTRL write 0xF9 reads back 0x09.
